// File: rtl/lcd_cmd_sched.sv
// lcd_cmd_sched: FIFO-buffered command scheduler in front of the LCD image controller.
// Optional busy watchdog is compiled in when LCD_SCHED_TIMEOUT_EN is defined.
module lcd_cmd_sched #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned TIMEOUT    = 256
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [2:0]                    in_cmd,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          lcd_busy,
    input  logic                          lcd_done,
    output logic [2:0]                    cmd,
    output logic                          cmd_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [CNT_W-1:0]              issued_cnt,
    output logic                          sched_done,
    output logic                          err_timeout
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_params
        $error("lcd_cmd_sched: FIFO_DEPTH must be a power of 2 >= 2 and TIMEOUT >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_HALT
    } state_t;

    state_t         state;
    logic [2:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           write_seen;
    logic           push;
    logic           pop;

`ifdef LCD_SCHED_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd;
`else
    assign err_timeout = 1'b0;
`endif

    // A full FIFO refuses pushes even when a pop happens in the same cycle.
    assign in_ready = (fifo_count != FULL_CNT) && !write_seen && (state != S_HALT);
    assign push     = in_valid && in_ready;
    assign pop      = (state == S_IDLE) && !lcd_busy && (fifo_count != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_cmd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            write_seen <= 1'b0;
            cmd        <= '0;
            cmd_valid  <= 1'b0;
            issued_cnt <= '0;
            sched_done <= 1'b0;
`ifdef LCD_SCHED_TIMEOUT_EN
            wd          <= '0;
            err_timeout <= 1'b0;
`endif
        end else begin
            cmd_valid <= 1'b0;

            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (in_cmd == 3'd0) begin
                    write_seen <= 1'b1;
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase

            // The ISSUE-cycle outputs are loaded on entry so they are visible during ISSUE.
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        state     <= S_ISSUE;
                        cmd       <= mem[rd_ptr];
                        cmd_valid <= 1'b1;
                        if (issued_cnt != '1) begin
                            issued_cnt <= issued_cnt + 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    state <= S_WAIT_ACK;
`ifdef LCD_SCHED_TIMEOUT_EN
                    wd    <= '0;
`endif
                end
                S_WAIT_ACK: begin
                    if (lcd_busy) begin
                        state <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (!lcd_busy) begin
                        if (cmd != 3'd0) begin
                            state <= S_IDLE;
                        end else if (lcd_done) begin
                            state      <= S_HALT;
                            sched_done <= 1'b1;
                        end
                    end
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

`ifdef LCD_SCHED_TIMEOUT_EN
            // Later assignment overrides the normal wait-state transition on expiry.
            if (state == S_WAIT_ACK || state == S_WAIT_DONE) begin
                if (wd == WD_W'(TIMEOUT - 1)) begin
                    err_timeout <= 1'b1;
                    state       <= S_HALT;
                end else begin
                    wd <= wd + 1'b1;
                end
            end
`endif
        end
    end
endmodule

// File: tb/tb_lcd_cmd_sched.sv
// Self-checking bench for lcd_cmd_sched: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_lcd_cmd_sched;
    localparam int DEPTH = 8;
    localparam int TO    = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  in_cmd = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        lcd_busy = 1'b0;
    logic        lcd_done = 1'b0;
    logic [2:0]  cmd;
    logic        cmd_valid;
    logic [3:0]  fifo_count;
    logic [15:0] issued_cnt;
    logic        sched_done;
    logic        err_timeout;

    always #5 clk = ~clk;

    lcd_cmd_sched #(.FIFO_DEPTH(DEPTH), .CNT_W(16), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .in_cmd(in_cmd), .in_valid(in_valid), .in_ready(in_ready),
        .lcd_busy(lcd_busy), .lcd_done(lcd_done), .cmd(cmd), .cmd_valid(cmd_valid),
        .fifo_count(fifo_count), .issued_cnt(issued_cnt), .sched_done(sched_done),
        .err_timeout(err_timeout)
    );

    // Reference model. Phase: 0 free to issue, 1 strobing, 2 awaiting busy rise,
    // 3 awaiting busy fall, 4 halted.
    logic [2:0] mq[$];
    int         m_phase  = 0;
    logic [2:0] m_cmd    = '0;
    bit         m_strobe = 0;
    bit         m_sdone  = 0;
    bit         m_err    = 0;
    bit         m_ws     = 0;
    int         m_issued = 0;
    int         m_wait   = 0;

    always @(posedge clk) begin : model
        bit acc;
        bit iss;
        int ph;
        ph  = m_phase;
        acc = in_valid && (mq.size() < DEPTH) && !m_ws && (ph != 4);
        iss = (ph == 0) && !lcd_busy && (mq.size() != 0);
        if (reset) begin
            mq.delete();
            m_phase = 0; m_cmd = '0; m_strobe = 0; m_sdone = 0;
            m_err = 0; m_ws = 0; m_issued = 0; m_wait = 0;
        end else begin
            m_strobe = iss;
            if (iss) begin
                m_cmd = mq.pop_front();
                if (m_issued < 65535) m_issued++;
                m_phase = 1;
            end else if (ph == 1) begin
                m_phase = 2;
                m_wait  = 0;
            end else if (ph == 2 && lcd_busy) begin
                m_phase = 3;
            end else if (ph == 3 && !lcd_busy) begin
                if (m_cmd != 3'd0) m_phase = 0;
                else if (lcd_done) begin
                    m_phase = 4;
                    m_sdone = 1;
                end
            end
`ifdef LCD_SCHED_TIMEOUT_EN
            if (ph == 2 || ph == 3) begin
                if (m_wait == TO - 1) begin
                    m_err   = 1;
                    m_phase = 4;
                end else m_wait++;
            end
`endif
            if (acc) begin
                mq.push_back(in_cmd);
                if (in_cmd == 3'd0) m_ws = 1;
            end
        end
    end

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    bit         auto_lcd = 0;
    int         busy_left = 0;
    logic [2:0] s_cmd[$];
    int         s_cyc[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        check("cmd_valid", int'(cmd_valid), int'(m_strobe));
        check("cmd", int'(cmd), int'(m_cmd));
        check("fifo_count", int'(fifo_count), mq.size());
        check("issued_cnt", int'(issued_cnt), m_issued);
        check("sched_done", int'(sched_done), int'(m_sdone));
        check("err_timeout", int'(err_timeout), int'(m_err));
        check("in_ready", int'(in_ready), int'((mq.size() < DEPTH) && !m_ws && (m_phase != 4)));
        if (cmd_valid) begin
            s_cmd.push_back(cmd);
            s_cyc.push_back(cyc);
        end
        // Auto LCD: busy rises one cycle after a strobe and stays high two cycles.
        if (auto_lcd) begin
            if (busy_left > 0) begin
                lcd_busy = 1'b1;
                busy_left--;
            end else lcd_busy = 1'b0;
            if (cmd_valid) busy_left = 2;
        end
    endtask

    task automatic push(input logic [2:0] c);
        in_cmd   = c;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; lcd_busy = 1'b0; lcd_done = 1'b0;
        auto_lcd = 0; busy_left = 0;
        tick(); tick();
        reset = 1'b0;
        s_cmd.delete();
        s_cyc.delete();
    endtask

    task automatic wait_strobe(input int max);
        int n = 0;
        while (!cmd_valid && n < max) begin
            tick();
            n++;
        end
        check("strobe_wait", int'(cmd_valid), 1);
    endtask

    initial begin
        int p0;
        int n0;
        logic [2:0] exp2 [4] = '{3'd1, 3'd4, 3'd5, 3'd6};

        do_reset();
        check("rst_fifo_count", int'(fifo_count), 0);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_issued", int'(issued_cnt), 0);
        check("rst_cmd", int'(cmd), 0);
        check("rst_sched_done", int'(sched_done), 0);

        // Startup: LCD busy with image load holds the command in the FIFO.
        lcd_busy = 1'b1;
        push(3'd3);
        repeat (69) tick();
        check("s1_held_count", int'(fifo_count), 1);
        check("s1_no_strobe", s_cmd.size(), 0);
        lcd_busy = 1'b0;
        wait_strobe(10);
        check("s1_cmd", int'(cmd), 3);
        check("s1_issued", int'(issued_cnt), 1);

        // Ordered issue with a responsive LCD.
        do_reset();
        auto_lcd = 1;
        p0 = cyc;
        push(3'd1); push(3'd4); push(3'd5); push(3'd6);
        repeat (40) tick();
        check("s2_strobes", s_cmd.size(), 4);
        if (s_cmd.size() == 4) begin
            for (int i = 0; i < 4; i++) check("s2_order", int'(s_cmd[i]), int'(exp2[i]));
            check("s2_latency", s_cyc[0] - p0, 2);
            for (int i = 0; i < 3; i++) check("s2_spacing", s_cyc[i+1] - s_cyc[i], 5);
        end
        check("s2_issued", int'(issued_cnt), 4);

        // Overfill with LCD busy, then drain with wrap-around pushes.
        do_reset();
        lcd_busy = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) push(3'((i % 7) + 1));
        check("s3_full_count", int'(fifo_count), 8);
        check("s3_full_ready", int'(in_ready), 0);
        auto_lcd = 1;
        lcd_busy = 1'b0;
        for (int j = 0; j < 90; j++) begin
            if (j % 6 == 0 && j <= 18) push(3'((j % 5) + 1));
            else tick();
        end
        check("s3_drained", int'(fifo_count), 0);
        check("s3_strobes", s_cmd.size(), 11);

        // Write-back is terminal.
        do_reset();
        push(3'd0);
        check("s4_ready_after_wb", int'(in_ready), 0);
        check("s4_count_after_wb", int'(fifo_count), 1);
        push(3'd2);
        check("s4_strobe_wb", int'(cmd_valid), 1);
        check("s4_cmd_wb", int'(cmd), 0);
        check("s4_refused", int'(fifo_count), 0);
        lcd_busy = 1'b1;
        tick(); tick();
        lcd_busy = 1'b0;
        lcd_done = 1'b0;
        repeat (3) tick();
        check("s4_wait_done", int'(sched_done), 0);
        lcd_done = 1'b1;
        tick(); tick();
        check("s4_sched_done", int'(sched_done), 1);
        n0 = s_cmd.size();
        push(3'd5);
        repeat (10) tick();
        check("s4_no_more_strobes", s_cmd.size() - n0, 0);
        check("s4_halt_ready", int'(in_ready), 0);

        // Reset while waiting for busy to fall with three commands queued.
        do_reset();
        push(3'd7); push(3'd2); push(3'd3); push(3'd4);
        lcd_busy = 1'b1;
        repeat (3) tick();
        check("s5_queued", int'(fifo_count), 3);
        check("s5_issued", int'(issued_cnt), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("s5_rst_count", int'(fifo_count), 0);
        check("s5_rst_issued", int'(issued_cnt), 0);
        check("s5_rst_valid", int'(cmd_valid), 0);
        check("s5_rst_ready", int'(in_ready), 1);
        n0 = s_cmd.size();
        lcd_busy = 1'b0;
        repeat (4) tick();
        check("s5_idle_quiet", s_cmd.size() - n0, 0);

`ifdef LCD_SCHED_TIMEOUT_EN
        // Busy stuck high after a strobe: 16 waiting cycles, then sticky error and halt.
        do_reset();
        push(3'd5);
        wait_strobe(5);
        p0 = cyc;
        lcd_busy = 1'b1;
        n0 = 0;
        while (!err_timeout && n0 < 30) begin
            tick();
            n0++;
        end
        check("s6_err", int'(err_timeout), 1);
        check("s6_err_cycle", cyc - p0, 17);
        check("s6_no_sched_done", int'(sched_done), 0);
        repeat (3) tick();
        check("s6_sticky", int'(err_timeout), 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish by 100000, required finish");
        $fatal(1);
    end
endmodule
